// File: rtl/axi_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : axi_perf_monitor
// Brief    : Passive AXI performance monitor. Counts channel handshakes and
//            instruction commits, tracks outstanding read/write bursts,
//            flags protocol errors and stalled channels, and (optionally)
//            measures AR-to-RLAST read latency.
// Options  : AXI_MON_LATENCY_EN - include the read timestamp FIFO and the
//            rd_lat_last / rd_lat_max logic; otherwise both read as 0.
// Revision : 1.0 - initial release
// ============================================================================
module axi_perf_monitor #(
    parameter int CNT_W   = 32,
    parameter int MAX_OUT = 8,
    parameter int LAT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     arvalid,
    input  logic                     arready,
    input  logic                     rvalid,
    input  logic                     rready,
    input  logic                     rlast,
    input  logic                     awvalid,
    input  logic                     awready,
    input  logic                     wvalid,
    input  logic                     wready,
    input  logic                     wlast,
    input  logic                     bvalid,
    input  logic                     bready,
    input  logic                     commit,
    output logic [CNT_W-1:0]         ar_cnt,
    output logic [CNT_W-1:0]         r_cnt,
    output logic [CNT_W-1:0]         aw_cnt,
    output logic [CNT_W-1:0]         w_cnt,
    output logic [CNT_W-1:0]         b_cnt,
    output logic [CNT_W-1:0]         commit_cnt,
    output logic [$clog2(MAX_OUT):0] rd_outstanding,
    output logic [$clog2(MAX_OUT):0] wr_outstanding,
    output logic [LAT_W-1:0]         rd_lat_last,
    output logic [LAT_W-1:0]         rd_lat_max,
    output logic                     rd_timeout,
    output logic                     wr_timeout,
    output logic                     proto_err
);

    localparam int c_OUT_W = $clog2(MAX_OUT) + 1;
    localparam int c_WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [c_OUT_W-1:0] c_OUT_ONE  = c_OUT_W'(1);
    localparam logic [c_OUT_W-1:0] c_OUT_MAX  = c_OUT_W'(MAX_OUT);
    localparam logic [c_WD_W-1:0]  c_WD_ONE   = c_WD_W'(1);
    localparam logic [c_WD_W-1:0]  c_WD_TO    = c_WD_W'(TIMEOUT);
    localparam logic [c_WD_W-1:0]  c_WD_TO_M1 = c_WD_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic w_ar_hs, w_r_hs, w_rl_hs, w_aw_hs, w_w_hs, w_b_hs;

    assign w_ar_hs = arvalid & arready;
    assign w_r_hs  = rvalid  & rready;
    assign w_rl_hs = w_r_hs  & rlast;
    assign w_aw_hs = awvalid & awready;
    assign w_w_hs  = wvalid  & wready;
    assign w_b_hs  = bvalid  & bready;

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v,
                                                   input logic             en);
        if (en && (v != c_CNT_MAX)) begin
            return v + c_CNT_ONE;
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_ar_cnt, r_r_cnt, r_aw_cnt, r_w_cnt, r_b_cnt, r_commit_cnt;

    // Event counters: clear takes priority over any same-cycle event
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ar_cnt     <= '0;
            r_r_cnt      <= '0;
            r_aw_cnt     <= '0;
            r_w_cnt      <= '0;
            r_b_cnt      <= '0;
            r_commit_cnt <= '0;
        end else if (clear) begin
            r_ar_cnt     <= '0;
            r_r_cnt      <= '0;
            r_aw_cnt     <= '0;
            r_w_cnt      <= '0;
            r_b_cnt      <= '0;
            r_commit_cnt <= '0;
        end else begin
            r_ar_cnt     <= f_sat_inc(r_ar_cnt,     w_ar_hs);
            r_r_cnt      <= f_sat_inc(r_r_cnt,      w_r_hs);
            r_aw_cnt     <= f_sat_inc(r_aw_cnt,     w_aw_hs);
            r_w_cnt      <= f_sat_inc(r_w_cnt,      w_w_hs);
            r_b_cnt      <= f_sat_inc(r_b_cnt,      w_b_hs);
            r_commit_cnt <= f_sat_inc(r_commit_cnt, commit);
        end
    end

    // ------------------------------------------------------------------
    // Free-running cycle timestamp (wraps, ignores clear)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cycle;

    // Cycle timestamp used to stamp read requests
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding burst tracking
    // ------------------------------------------------------------------
    logic [c_OUT_W-1:0] r_rd_out, r_wr_out;
    logic [c_OUT_W-1:0] w_rd_out_nxt, w_wr_out_nxt;
    logic               w_rd_err, w_wr_err;

    // Read outstanding next value; over/underflow holds the count and flags
    always_comb begin
        w_rd_out_nxt = r_rd_out;
        w_rd_err     = 1'b0;
        if (w_ar_hs && !w_rl_hs) begin
            if (r_rd_out == c_OUT_MAX) begin
                w_rd_err = 1'b1;
            end else begin
                w_rd_out_nxt = r_rd_out + c_OUT_ONE;
            end
        end else if (w_rl_hs && !w_ar_hs) begin
            if (r_rd_out == '0) begin
                w_rd_err = 1'b1;
            end else begin
                w_rd_out_nxt = r_rd_out - c_OUT_ONE;
            end
        end
    end

    // Write outstanding next value; AW opens a burst, B closes it
    always_comb begin
        w_wr_out_nxt = r_wr_out;
        w_wr_err     = 1'b0;
        if (w_aw_hs && !w_b_hs) begin
            if (r_wr_out == c_OUT_MAX) begin
                w_wr_err = 1'b1;
            end else begin
                w_wr_out_nxt = r_wr_out + c_OUT_ONE;
            end
        end else if (w_b_hs && !w_aw_hs) begin
            if (r_wr_out == '0) begin
                w_wr_err = 1'b1;
            end else begin
                w_wr_out_nxt = r_wr_out - c_OUT_ONE;
            end
        end
    end

    // Outstanding counts track the bus even while statistics are cleared
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_out <= '0;
            r_wr_out <= '0;
        end else begin
            r_rd_out <= w_rd_out_nxt;
            r_wr_out <= w_wr_out_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky protocol error
    // ------------------------------------------------------------------
    logic r_proto_err;

    // Protocol error flag accumulates until clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_proto_err <= 1'b0;
        end else if (clear) begin
            r_proto_err <= 1'b0;
        end else if (w_rd_err || w_wr_err) begin
            r_proto_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stall watchdogs
    // ------------------------------------------------------------------
    logic [c_WD_W-1:0] r_rd_wd, r_wr_wd;
    logic              r_rd_timeout, r_wr_timeout;
    logic              w_rd_stall, w_wr_stall;

    // A channel is stalled when work is pending and nothing moves on it
    assign w_rd_stall = ((r_rd_out != '0) | arvalid) & ~(w_ar_hs | w_r_hs);
    assign w_wr_stall = ((r_wr_out != '0) | awvalid | wvalid) &
                        ~(w_aw_hs | w_w_hs | w_b_hs);

    // Read watchdog: counts consecutive stall cycles, saturating at TIMEOUT
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_wd      <= '0;
            r_rd_timeout <= 1'b0;
        end else if (clear) begin
            r_rd_wd      <= '0;
            r_rd_timeout <= 1'b0;
        end else if (w_rd_stall) begin
            if (r_rd_wd != c_WD_TO) begin
                r_rd_wd <= r_rd_wd + c_WD_ONE;
            end
            if (r_rd_wd == c_WD_TO_M1) begin
                r_rd_timeout <= 1'b1;
            end
        end else begin
            r_rd_wd <= '0;
        end
    end

    // Write watchdog: same behaviour over the AW/W/B channels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_wd      <= '0;
            r_wr_timeout <= 1'b0;
        end else if (clear) begin
            r_wr_wd      <= '0;
            r_wr_timeout <= 1'b0;
        end else if (w_wr_stall) begin
            if (r_wr_wd != c_WD_TO) begin
                r_wr_wd <= r_wr_wd + c_WD_ONE;
            end
            if (r_wr_wd == c_WD_TO_M1) begin
                r_wr_timeout <= 1'b1;
            end
        end else begin
            r_wr_wd <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Read latency measurement
    // ------------------------------------------------------------------
    logic w_unused;

`ifdef AXI_MON_LATENCY_EN
    localparam int c_PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    logic [CNT_W-1:0]   r_ts_mem [MAX_OUT];
    logic [c_PTR_W-1:0] r_wptr, r_rptr;
    logic [LAT_W-1:0]   r_lat_last, r_lat_max;
    logic               w_rd_push, w_rd_pop, w_fifo_empty;
    logic               w_mem_wr, w_mem_rd;
    logic [CNT_W-1:0]   w_diff;
    logic [LAT_W-1:0]   w_lat;

    // FIFO occupancy always equals the read outstanding count
    assign w_fifo_empty = (r_rd_out == '0);
    assign w_rd_push    = w_ar_hs & (w_rl_hs | (r_rd_out != c_OUT_MAX));
    assign w_rd_pop     = w_rl_hs & (w_ar_hs | ~w_fifo_empty);

    // Push+pop on an empty FIFO bypasses storage and yields zero latency
    assign w_mem_wr = w_rd_push & ~(w_rd_pop & w_fifo_empty);
    assign w_mem_rd = w_rd_pop & ~w_fifo_empty;
    assign w_diff   = w_fifo_empty ? '0 : (r_cycle - r_ts_mem[r_rptr]);

    if (CNT_W > LAT_W) begin : g_lat_sat
        assign w_lat = (|w_diff[CNT_W-1:LAT_W]) ? {LAT_W{1'b1}} : w_diff[LAT_W-1:0];
    end else begin : g_lat_ext
        assign w_lat = LAT_W'(w_diff);
    end

    // Timestamp storage; contents are only meaningful behind the pointers
    always_ff @(posedge clock) begin
        if (w_mem_wr) begin
            r_ts_mem[r_wptr] <= r_cycle;
        end
    end

    // FIFO pointers advance regardless of clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_mem_wr) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_mem_rd) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

    // Latency statistics update on every completed read burst
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lat_last <= '0;
            r_lat_max  <= '0;
        end else if (clear) begin
            r_lat_last <= '0;
            r_lat_max  <= '0;
        end else if (w_rd_pop) begin
            r_lat_last <= w_lat;
            if (w_lat > r_lat_max) begin
                r_lat_max <= w_lat;
            end
        end
    end

    assign rd_lat_last = r_lat_last;
    assign rd_lat_max  = r_lat_max;
    assign w_unused    = wlast;
`else
    assign rd_lat_last = '0;
    assign rd_lat_max  = '0;
    assign w_unused    = ^{wlast, r_cycle};
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ar_cnt         = r_ar_cnt;
    assign r_cnt          = r_r_cnt;
    assign aw_cnt         = r_aw_cnt;
    assign w_cnt          = r_w_cnt;
    assign b_cnt          = r_b_cnt;
    assign commit_cnt     = r_commit_cnt;
    assign rd_outstanding = r_rd_out;
    assign wr_outstanding = r_wr_out;
    assign rd_timeout     = r_rd_timeout;
    assign wr_timeout     = r_wr_timeout;
    assign proto_err      = r_proto_err;

endmodule
`default_nettype wire

// File: doc/axi_perf_monitor.md
AXI_PERF_MONITOR -- requirements
Module: axi_perf_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning width of every event counter and of the internal cycle timestamp.
REQ-002 SHALL have parameter MAX_OUT, default 8, meaning maximum outstanding read and write bursts tracked; must be a power of two and at least 2.
REQ-003 SHALL have parameter LAT_W, default 16, meaning width of the read-latency outputs.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning stall cycles before a timeout flag sets.
REQ-005 SHALL have port clock, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port clear, input, 1, meaning synchronous statistics clear.
REQ-008 SHALL have ports arvalid, arready, rvalid, rready, rlast, awvalid, awready, wvalid, wready, wlast, bvalid, bready, all inputs of width 1, meaning the observed AXI handshake signals.
REQ-009 SHALL have port commit, input, 1, meaning the core instruction-retire pulse.
REQ-010 SHALL have ports ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, commit_cnt, all outputs of width CNT_W, meaning event counters.
REQ-011 SHALL have ports rd_outstanding and wr_outstanding, outputs of width $clog2(MAX_OUT)+1, meaning live outstanding burst counts.
REQ-012 SHALL have ports rd_lat_last and rd_lat_max, outputs of width LAT_W, meaning the last and the maximum read-burst latency.
REQ-013 SHALL have ports rd_timeout, wr_timeout and proto_err, outputs of width 1, meaning sticky error flags.

Function
REQ-014 SHALL define a handshake as valid AND ready in the same cycle; counters SHALL update on the next edge.
REQ-015 SHALL increment ar_cnt, aw_cnt and b_cnt per handshake, r_cnt and w_cnt per beat handshake, and commit_cnt per commit cycle.
REQ-016 SHALL saturate every event counter at all-ones (no wrap).
REQ-017 SHALL keep a free-running CNT_W cycle counter that wraps modulo 2^CNT_W and is unaffected by clear.
REQ-018 SHALL increment rd_outstanding on AR handshake and decrement it on an R handshake with rlast; both in one cycle SHALL leave it unchanged.
REQ-019 SHALL apply the same rule to wr_outstanding, with AW handshake as increment and B handshake as decrement.
REQ-020 SHALL, on a decrement with count 0, set proto_err and hold the count at 0.
REQ-021 SHALL, on an increment with count MAX_OUT and no simultaneous decrement, set proto_err and hold the count at MAX_OUT.
REQ-022 SHALL maintain a read timestamp FIFO of depth MAX_OUT, pushing the cycle-counter value on each accepted AR increment and popping on each accepted rlast decrement; push and pop in one cycle SHALL both occur.
REQ-023 SHALL, on pop, set rd_lat_last = (cycle − popped timestamp) saturated to LAT_W; an AR and rlast with an empty FIFO in one cycle SHALL give latency 0.
REQ-024 SHALL update rd_lat_max to the new latency when that latency is greater than the current value.
REQ-025 SHALL make the read watchdog count cycles in which (rd_outstanding≠0 OR arvalid) and no AR/R handshake occurs, and zero it otherwise.
REQ-026 SHALL set rd_timeout when the read watchdog reaches TIMEOUT; the flag is sticky.
REQ-027 SHALL make the write watchdog behave identically over wr_outstanding, awvalid, wvalid and the AW/W/B handshakes, driving wr_timeout.
REQ-028 SHALL make clear zero event counters, rd_lat_last, rd_lat_max, watchdogs and sticky flags, and SHALL NOT alter outstanding counts, the FIFO or the cycle counter.
REQ-029 SHALL, when clear coincides with events, let clear win for statistics while outstanding counts and the FIFO still update.

Reset
REQ-030 SHALL, while reset is low, force all outputs, counters, FIFO pointers and flags to 0 immediately, independent of clock.
REQ-031 SHALL ignore handshakes on the first edge after reset deasserts only if reset is still low at that edge.

Configuration
REQ-032 SHALL, with AXI_MON_LATENCY_EN defined, include the FIFO and latency logic of REQ-022 to REQ-024.
REQ-033 SHALL, without AXI_MON_LATENCY_EN, omit the FIFO and tie rd_lat_last and rd_lat_max to 0; all other behaviour is unchanged.

Verification
REQ-034 SHALL cover: 3 AR handshakes, then 3 rlast beats 5 cycles apart -> ar_cnt=3, rd_outstanding 1,2,3 then back to 0, proto_err=0.
REQ-035 SHALL cover: AR at cycle 10 with 4-beat R ending at rlast cycle 30, then AR at 40 with rlast at 45 (LATENCY_EN) -> rd_lat_last=20 then 5, rd_lat_max=20.
REQ-036 SHALL cover: rlast handshake with rd_outstanding=0 -> proto_err=1, rd_outstanding=0.
REQ-037 SHALL cover: TIMEOUT=16, AW handshake with no B for 16 cycles -> wr_timeout=1 after cycle 16 and stays 1 until clear.
REQ-038 SHALL cover: CNT_W=4 with 20 commits -> commit_cnt=15; clear with 2 reads outstanding -> counters 0, rd_outstanding=2.
REQ-039 SHALL cover: reset low mid-burst with rd_outstanding=2 -> all outputs 0 asynchronously, before the next clock edge.
